// File: rtl/ptm_pkg.sv
// ptm_pkg: shared types for the pulse timing monitor.
// Result fields are PTM_CNT_W wide; narrower monitors zero-extend into them.
package ptm_pkg;
  localparam int PTM_CNT_W = 16;
  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} ptm_state_e;
  typedef struct packed {
    logic [PTM_CNT_W-1:0] phase;
    logic [PTM_CNT_W-1:0] ton;
    logic [PTM_CNT_W-1:0] toff;
    logic                 overflow;
  } ptm_result_t;
endpackage

// File: rtl/pulse_timing_monitor_if.sv
// pulse_timing_monitor_if: valid/ready result port of the pulse timing monitor
interface pulse_timing_monitor_if
  import ptm_pkg::*;
#(
  parameter int CNT_W = PTM_CNT_W
);
  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] ton_cnt;
  logic [CNT_W-1:0] toff_cnt;
  logic             overflow;
  logic             overrun;
  modport master (output meas_valid, phase_cnt, ton_cnt, toff_cnt, overflow, overrun, input meas_ready);
  modport slave (input meas_valid, phase_cnt, ton_cnt, toff_cnt, overflow, overrun, output meas_ready);
endinterface

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer with edge detection on the synchronized level
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
    prev_d = sync_q[SYNC_STAGES-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;
endmodule

// File: rtl/pulse_timing_monitor.sv
// pulse_timing_monitor: measures phase, high time and low time of an asynchronous waveform
// in clk cycles and posts each result on a valid/ready port (CNT_W must not exceed PTM_CNT_W).
module pulse_timing_monitor
  import ptm_pkg::*;
#(
  parameter int CNT_W       = PTM_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  input  logic cont,
  input  logic sig_in,
  output logic busy,
  pulse_timing_monitor_if.master m
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  ptm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cont_q, cont_d, ovf_q, ovf_d, valid_q, valid_d, overrun_q, overrun_d;
  ptm_result_t      bld_q, bld_d, res_q, res_d;
  logic             rise, fall, lvl_unused, sat, accept, post;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .d_async(sig_in), .level(lvl_unused), .rise(rise), .fall(fall)
  );

  function automatic logic [PTM_CNT_W-1:0] ext(input logic [CNT_W-1:0] v);
    return PTM_CNT_W'(v);
  endfunction

  // Counter starts at 1 on accept so the captured phase is the distance from the accept cycle
  always_comb begin
    sat       = cnt_q == CNT_MAX;
    accept    = state_q == IDLE && start && !stop;
    post      = 1'b0;
    state_d   = state_q;
    cnt_d     = sat ? cnt_q : cnt_q + CNT_W'(1);
    cont_d    = cont_q;
    ovf_d     = ovf_q | (sat && state_q != IDLE);
    bld_d     = bld_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = ARM;
        cnt_d   = CNT_W'(1);
        cont_d  = cont;
        ovf_d   = 1'b0;
        bld_d   = '0;
      end
      ARM: if (rise) begin
        state_d     = HIGH;
        cnt_d       = CNT_W'(1);
        ovf_d       = ovf_q;
        bld_d.phase = ext(cnt_q);
      end
      HIGH: if (fall) begin
        state_d   = LOW;
        cnt_d     = CNT_W'(1);
        ovf_d     = ovf_q;
        bld_d.ton = ext(cnt_q);
      end
      LOW: if (rise) begin
        post        = 1'b1;
        state_d     = cont_q ? HIGH : IDLE;
        cnt_d       = CNT_W'(1);
        ovf_d       = 1'b0;
        bld_d.phase = '0;
      end
    endcase
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      post    = 1'b0;
    end
    res_d     = post ? '{phase: bld_q.phase, ton: bld_q.ton, toff: ext(cnt_q), overflow: ovf_q} : res_q;
    valid_d   = post | (valid_q & ~m.meas_ready);
    overrun_d = !accept && (overrun_q || (post && valid_q && !m.meas_ready));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cont_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bld_q     <= '0;
      res_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cont_q    <= cont_d;
      ovf_q     <= ovf_d;
      bld_q     <= bld_d;
      res_q     <= res_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy         = state_q != IDLE;
  assign m.meas_valid = valid_q;
  assign m.phase_cnt  = res_q.phase[CNT_W-1:0];
  assign m.ton_cnt    = res_q.ton[CNT_W-1:0];
  assign m.toff_cnt   = res_q.toff[CNT_W-1:0];
  assign m.overflow   = res_q.overflow;
  assign m.overrun    = overrun_q;
endmodule

// File: tb/tb_pulse_timing_monitor.sv
// tb_pulse_timing_monitor: randomized and directed checks of pulse_timing_monitor against
// a waveform-level model (phase = start-to-rise distance + sync latency, ton/toff = drive lengths).
module tb_pulse_timing_monitor;
  localparam int S = 2;
  logic clk = 0, rst_n = 1, start = 0, stop = 0, cont = 0, sig_in = 0, ready = 1, busy, busy4;
  int cyc = 0, n_pass = 0, n_chk = 0;
  typedef struct {int p; int t; int f; int o; int c;} res_t;
  res_t got[$], got4[$], exp_q[$];

  pulse_timing_monitor_if #(.CNT_W(16)) bif ();
  pulse_timing_monitor_if #(.CNT_W(4)) bif4 ();
  assign bif.meas_ready  = ready;
  assign bif4.meas_ready = ready;

  pulse_timing_monitor #(.CNT_W(16), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont), .sig_in(sig_in), .busy(busy), .m(bif)
  );
  pulse_timing_monitor #(.CNT_W(4), .SYNC_STAGES(S)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont), .sig_in(sig_in), .busy(busy4), .m(bif4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bif.meas_valid && ready)
      got.push_back('{int'(bif.phase_cnt), int'(bif.ton_cnt), int'(bif.toff_cnt), int'(bif.overflow), cyc});
    if (bif4.meas_valid && ready)
      got4.push_back('{int'(bif4.phase_cnt), int'(bif4.ton_cnt), int'(bif4.toff_cnt), int'(bif4.overflow), cyc});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: first result carries the phase, later continuous results report 0; c is the spacing
  function automatic void model(input int d, input int his[$], input int los[$], input bit c);
    exp_q.delete();
    for (int i = 0; i < (c ? his.size() : 1); i++)
      exp_q.push_back('{i == 0 ? d + S : 0, his[i], los[i], 0, his[i] + los[i]});
  endfunction

  task automatic play(input int d, input int his[$], input int los[$], input bit c);
    start = 1; cont = c; tick(1); start = 0; cont = 0;
    tick(d - 1);
    for (int i = 0; i < his.size(); i++) begin
      sig_in = 1; tick(his[i]); sig_in = 0; tick(los[i]);
    end
    sig_in = 1; tick(S + 3);
    stop = 1; tick(1); stop = 0; sig_in = 0; tick(S + 3);
  endtask

  task automatic test_reset();
    rst_n = 0; tick(3);
    n_chk++;
    if ({busy, bif.meas_valid, bif.overflow, bif.overrun} !== 4'b0 || bif.phase_cnt !== 0 || bif.ton_cnt !== 0 || bif.toff_cnt !== 0)
      $display("FAIL reset_outputs: busy=%b valid=%b ovf=%b ovr=%b p=%0d t=%0d f=%0d, want all 0",
               busy, bif.meas_valid, bif.overflow, bif.overrun, bif.phase_cnt, bif.ton_cnt, bif.toff_cnt);
    else n_pass++;
    rst_n = 1; tick(3);
    n_chk++;
    if (busy !== 0 || bif.meas_valid !== 0) $display("FAIL reset_release: busy=%b valid=%b, want 0 0", busy, bif.meas_valid);
    else n_pass++;
  endtask

  task automatic test_phase_duty();
    int h[$], l[$];
    h = {5}; l = {5};
    got.delete(); model(10, h, l, 0); play(10, h, l, 0);
    n_chk++;
    if (got.size() != 1) $display("FAIL duty_count: got %0d results, want 1", got.size()); else n_pass++;
    if (got.size() > 0) begin
      n_chk++;
      if (got[0].p !== 10 + S || got[0].t !== 5 || got[0].f !== 5 || got[0].o !== 0)
        $display("FAIL duty_result: got p=%0d t=%0d f=%0d o=%0d want p=%0d t=5 f=5 o=0", got[0].p, got[0].t, got[0].f, got[0].o, 10 + S);
      else n_pass++;
    end
    n_chk++;
    if (busy !== 0) $display("FAIL duty_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_continuous();
    int h[$], l[$];
    h = {3, 3, 3, 3}; l = {7, 7, 7, 7};
    got.delete(); model(5, h, l, 1); play(5, h, l, 1);
    n_chk++;
    if (got.size() != exp_q.size()) $display("FAIL cont_count: got %0d want %0d", got.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_chk++;
      if (got[i].p !== exp_q[i].p || got[i].t !== exp_q[i].t || got[i].f !== exp_q[i].f || got[i].o !== exp_q[i].o ||
          (i > 0 && got[i].c - got[i-1].c !== exp_q[i].c))
        $display("FAIL cont_result[%0d]: got p=%0d t=%0d f=%0d o=%0d want p=%0d t=%0d f=%0d o=%0d period %0d",
                 i, got[i].p, got[i].t, got[i].f, got[i].o, exp_q[i].p, exp_q[i].t, exp_q[i].f, exp_q[i].o, exp_q[i].c);
      else n_pass++;
    end
    n_chk++;
    if (bif.overrun !== 0) $display("FAIL cont_overrun: got %b want 0", bif.overrun); else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      int h[$], l[$], d, n;
      bit c;
      c = 1'($urandom_range(0, 1));
      n = c ? int'($urandom_range(1, 4)) : 1;
      d = int'($urandom_range(2, 20));
      for (int i = 0; i < n; i++) begin
        h.push_back(int'($urandom_range(1, 8)));
        l.push_back(int'($urandom_range(1, 8)));
      end
      got.delete(); model(d, h, l, c); play(d, h, l, c);
      n_chk++;
      if (got.size() != exp_q.size()) $display("FAIL rand%0d_count: got %0d want %0d", k, got.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        n_chk++;
        if (got[i].p !== exp_q[i].p || got[i].t !== exp_q[i].t || got[i].f !== exp_q[i].f || got[i].o !== exp_q[i].o ||
            (i > 0 && got[i].c - got[i-1].c !== exp_q[i].c))
          $display("FAIL rand%0d_result[%0d]: got p=%0d t=%0d f=%0d o=%0d want p=%0d t=%0d f=%0d o=%0d",
                   k, i, got[i].p, got[i].t, got[i].f, got[i].o, exp_q[i].p, exp_q[i].t, exp_q[i].f, exp_q[i].o);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    int h[$], l[$];
    h = {2, 5, 4}; l = {8, 5, 6};
    got.delete(); ready = 0; play(4, h, l, 1);
    n_chk++;
    if (bif.meas_valid !== 1 || bif.phase_cnt !== 0 || bif.ton_cnt !== 4 || bif.toff_cnt !== 6 || bif.overrun !== 1)
      $display("FAIL bp_hold: valid=%b p=%0d t=%0d f=%0d ovr=%b want valid=1 p=0 t=4 f=6 ovr=1",
               bif.meas_valid, bif.phase_cnt, bif.ton_cnt, bif.toff_cnt, bif.overrun);
    else n_pass++;
    ready = 1; tick(1);
    n_chk++;
    if (bif.meas_valid !== 0 || bif.overrun !== 1 || got.size() != 1)
      $display("FAIL bp_drain: valid=%b ovr=%b taken=%0d want 0 1 1", bif.meas_valid, bif.overrun, got.size());
    else n_pass++;
    start = 1; tick(1); start = 0;
    n_chk++;
    if (bif.overrun !== 0) $display("FAIL bp_overrun_clear: got %b want 0", bif.overrun); else n_pass++;
    stop = 1; tick(1); stop = 0; tick(1);
  endtask

  task automatic test_saturation();
    int h[$], l[$];
    h = {20}; l = {5};
    got.delete(); got4.delete(); play(3, h, l, 0);
    n_chk++;
    if (got4.size() != 1 || got4[0].t !== 15 || got4[0].o !== 1 || got4[0].f !== 5 || got4[0].p !== 3 + S)
      $display("FAIL sat_narrow: n=%0d t=%0d o=%0d f=%0d p=%0d want n=1 t=15 o=1 f=5 p=%0d",
               got4.size(), got4.size() ? got4[0].t : -1, got4.size() ? got4[0].o : -1,
               got4.size() ? got4[0].f : -1, got4.size() ? got4[0].p : -1, 3 + S);
    else n_pass++;
    n_chk++;
    if (got.size() != 1 || got[0].t !== 20 || got[0].o !== 0)
      $display("FAIL sat_wide: n=%0d t=%0d o=%0d want n=1 t=20 o=0", got.size(), got.size() ? got[0].t : -1, got.size() ? got[0].o : -1);
    else n_pass++;
  endtask

  task automatic test_abort();
    got.delete();
    start = 1; tick(1); start = 0; tick(2);
    sig_in = 1; tick(5);
    n_chk++;
    if (busy !== 1) $display("FAIL abort_busy_before: got %b want 1", busy); else n_pass++;
    stop = 1; tick(1); stop = 0;
    n_chk++;
    if (busy !== 0) $display("FAIL abort_stop_high: busy=%b want 0", busy); else n_pass++;
    sig_in = 0; tick(5); sig_in = 1; tick(5); sig_in = 0; tick(S + 3);
    n_chk++;
    if (got.size() != 0 || bif.meas_valid !== 0) $display("FAIL abort_no_result: n=%0d valid=%b want 0 0", got.size(), bif.meas_valid);
    else n_pass++;
    start = 1; stop = 1; tick(1); start = 0; stop = 0;
    n_chk++;
    if (busy !== 0) $display("FAIL start_stop_same: busy=%b want 0", busy); else n_pass++;
    got.delete();
    start = 1; tick(1); start = 0; tick(1);
    start = 1; cont = 1; tick(1); start = 0; cont = 0; tick(1);
    sig_in = 1; tick(3); sig_in = 0; tick(4); sig_in = 1; tick(S + 3);
    n_chk++;
    if (busy !== 0 || got.size() != 1 || got[0].p !== 4 + S || got[0].t !== 3 || got[0].f !== 4)
      $display("FAIL start_while_busy: busy=%b n=%0d p=%0d t=%0d f=%0d want busy=0 n=1 p=%0d t=3 f=4",
               busy, got.size(), got.size() ? got[0].p : -1, got.size() ? got[0].t : -1, got.size() ? got[0].f : -1, 4 + S);
    else n_pass++;
    sig_in = 0; tick(S + 3);
  endtask

  task automatic test_reset_mid();
    int h[$], l[$];
    h = {2}; l = {3};
    ready = 0; play(3, h, l, 0);
    n_chk++;
    if (bif.meas_valid !== 1) $display("FAIL rstmid_pending: valid=%b want 1", bif.meas_valid); else n_pass++;
    start = 1; tick(1); start = 0; tick(2);
    sig_in = 1; tick(3); sig_in = 0; tick(4);
    rst_n = 0; #1;
    n_chk++;
    if ({busy, bif.meas_valid, bif.overflow, bif.overrun} !== 4'b0 || bif.phase_cnt !== 0 || bif.ton_cnt !== 0 || bif.toff_cnt !== 0)
      $display("FAIL rstmid_outputs: busy=%b valid=%b ovf=%b ovr=%b p=%0d t=%0d f=%0d want all 0",
               busy, bif.meas_valid, bif.overflow, bif.overrun, bif.phase_cnt, bif.ton_cnt, bif.toff_cnt);
    else n_pass++;
    tick(2); rst_n = 1; ready = 1; got.delete();
    sig_in = 1; tick(5); sig_in = 0; tick(5); sig_in = 1; tick(5); sig_in = 0; tick(S + 3);
    n_chk++;
    if (got.size() != 0 || busy !== 0 || bif.meas_valid !== 0)
      $display("FAIL rstmid_quiet: n=%0d busy=%b valid=%b want 0 0 0", got.size(), busy, bif.meas_valid);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks done", n_chk);
    $fatal(1);
  end

  initial begin
    tick(1);
    test_reset();
    test_phase_duty();
    test_continuous();
    test_random();
    test_backpressure();
    test_saturation();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pulse_timing_monitor.md
Name: pulse_timing_monitor

Overview:
Synthesizable measurement stage that consumes a generated pulse/clock waveform (phase, on-time, off-time) and reports its timing in units of the 100 MHz system clock.
- Samples the asynchronous waveform through a synchronizer.
- Measures the phase from arm to the first rising edge, the high time and the low time.
- Posts each result on a valid/ready output port.
- Downstream consumer of the team's programmable clock generators; used both in silicon self-check and in benches as a checker.

Parameters:
CNT_W, 16, width of phase/high/low counters and result fields.
SYNC_STAGES, 2, number of flops in the sig_in synchronizer (minimum 2).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle arm request; accepted only when IDLE.
stop  input  1  abort; returns to IDLE and discards the measurement in progress.
cont  input  1  continuous mode, sampled on the start-accept cycle.
sig_in  input  1  asynchronous waveform under test.
busy  output  1  high whenever state != IDLE.
meas_valid  output  1  result available.
meas_ready  input  1  consumer accepts the result.
phase_cnt  output  CNT_W  cycles from start-accept to first rise-detect (0 for continuous results after the first).
ton_cnt  output  CNT_W  cycles from rise-detect to fall-detect.
toff_cnt  output  CNT_W  cycles from fall-detect to next rise-detect.
overflow  output  1  some field of this result saturated.
overrun  output  1  sticky: an unconsumed result was overwritten; cleared on start-accept.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- Reset values: all outputs 0, state IDLE, synchronizer flops 0.
- Reset mid-operation: immediate return to the reset state; no partial result is posted.
- Synchronizer and edge detect:
  - s = sig_in after SYNC_STAGES flops; s_d = s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Phase includes the fixed synchronizer latency; no compensation.
- States: IDLE, ARM, HIGH, LOW.
- IDLE: start & ~stop -> ARM. The counter is cleared, cont is latched, overrun is cleared.
- ARM:
  - Counter increments each cycle.
  - On rise: phase = counter value at the rise-detect cycle (distance in cycles from start-accept). Go to HIGH with counter = 1.
- HIGH: on fall, ton = counter. Go to LOW with counter = 1.
- LOW:
  - On rise, toff = counter and the result is posted.
  - Next state is HIGH with counter = 1 if cont latched, else IDLE.
- Counters saturate at 2^CNT_W-1. Saturation sets the overflow bit of the result being built; the FSM keeps waiting for the edge. stop is the only exit from a stuck waveform.
- stop in any non-IDLE state -> IDLE next cycle. stop has priority over start and over an edge in the same cycle; no result is posted.
- start while busy is ignored.
- Result posting:
  - Output registers load on the cycle after the posting rise-detect; meas_valid = 1 that cycle.
  - meas_valid holds until the cycle meas_valid & meas_ready is seen, then drops next cycle unless a new result loads.
  - New result while meas_valid = 1 and no handshake that cycle: overwrite and set overrun.
  - New result in the same cycle as a handshake: load, meas_valid stays 1, overrun unaffected.
  - Fields stay stable while meas_valid = 1 and not overwritten.
- Continuous mode: the second and later results report phase_cnt = 0. The rise that ends LOW also starts the next HIGH, so no edge is lost.
- Edge cases:
  - A glitch shorter than one clock after synchronization is invisible.
  - A one-cycle high pulse gives ton = 1.

Decomposition:
- Package ptm_pkg:
  - state enum (IDLE, ARM, HIGH, LOW)
  - default CNT_W constant
  - packed result struct {phase, ton, toff, overflow}
- Sub-module sync_edge_detect (parameter SYNC_STAGES; ports clk, rst_n, d_async, level, rise, fall), reusable by other monitors.

Test Plan:
1. Phase and 50% duty:
   - Stimulus: cont = 0, start at cycle 0; sig_in rises 10 cycles later, then high 5 / low 5.
   - Required: one result with ton = 5, toff = 5, phase = 10 + SYNC_STAGES ±1 (record the exact value once); busy drops; overflow = 0.
2. Continuous asymmetric:
   - Stimulus: cont = 1, waveform ton = 3, toff = 7, meas_ready = 1.
   - Required: a result every 10 cycles, each with ton = 3, toff = 7. The first has phase ≠ 0; the rest have phase = 0; overrun = 0.
3. Backpressure:
   - Stimulus: cont = 1, meas_ready = 0 for 25 cycles, period 10.
   - Required: meas_valid stays high, fields update to the newest result, overrun = 1 until the next start.
4. Saturation:
   - Stimulus: CNT_W = 4, sig_in held high 20 cycles then a normal low.
   - Required: ton = 15, overflow = 1.
5. Abort and collisions:
   - Stop in HIGH -> IDLE next cycle, no meas_valid.
   - Start and stop in the same cycle -> stays IDLE.
   - Start while busy -> ignored.
6. Reset mid-measurement: rst_n low during LOW -> all outputs 0 immediately; no result after release until a new start.
